// File: rtl/memory_request_responder.sv
// Memory-side responder for the load/store unit: a local word RAM for loads and stores,
// plus a byte transmit stream (I_OUTPUT) and a byte receive stream (I_INPUT) returned on the CDB.
module memory_request_responder #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RSV_ID_W = 4,
  parameter int INSTR_W  = 5,
  parameter int CDB_W    = RSV_ID_W + DATA_W,
  parameter logic [INSTR_W-1:0] I_LOAD   = INSTR_W'(1),
  parameter logic [INSTR_W-1:0] I_LOADB  = INSTR_W'(2),
  parameter logic [INSTR_W-1:0] I_LOADR  = INSTR_W'(3),
  parameter logic [INSTR_W-1:0] I_STORE  = INSTR_W'(4),
  parameter logic [INSTR_W-1:0] I_STOREB = INSTR_W'(5),
  parameter logic [INSTR_W-1:0] I_STORER = INSTR_W'(6),
  parameter logic [INSTR_W-1:0] I_OUTPUT = INSTR_W'(7),
  parameter logic [INSTR_W-1:0] I_INPUT  = INSTR_W'(8)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_valid,
  input  logic [INSTR_W-1:0]  i_opcode,
  input  logic [RSV_ID_W-1:0] i_rsv_id,
  input  logic [DATA_W-1:0]   i_address,
  input  logic [DATA_W-1:0]   i_data,
  output logic                i_ready,
  output logic [CDB_W-1:0]    o_cdb,
  output logic                o_cdb_valid,
  input  logic                o_cdb_ready,
  output logic                o_tx_valid,
  output logic [7:0]          o_tx_data,
  input  logic                o_tx_ready,
  input  logic                i_rx_valid,
  input  logic [7:0]          i_rx_data,
  output logic                i_rx_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_RESP = 3'd2,
    S_TX   = 3'd3,
    S_RX   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  logic [RSV_ID_W-1:0] rsv_id_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [7:0]          tx_byte_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic                rd_stage_reg;
  logic [DATA_W-1:0]   ram_q;
  logic [DATA_W-1:0]   mem [2**ADDR_W];

  logic [ADDR_W-1:0] req_index;
  logic is_store, is_load, is_output, is_input;
  logic accept, ram_we, ram_re;
  logic unused_addr_bits;

  assign req_index        = i_address[ADDR_W-1:0];
  assign unused_addr_bits = ^i_address[DATA_W-1:ADDR_W];

  assign is_store  = (i_opcode == I_STORE) || (i_opcode == I_STOREB) || (i_opcode == I_STORER);
  assign is_load   = (i_opcode == I_LOAD)  || (i_opcode == I_LOADB)  || (i_opcode == I_LOADR);
  assign is_output = (i_opcode == I_OUTPUT);
  assign is_input  = (i_opcode == I_INPUT);

  assign accept = i_valid && i_ready;
  // A store seen while reset is asserted must not reach the RAM.
  assign ram_we = accept && is_store && !nrst;
  // READ spends one cycle fetching from the RAM and one capturing the result.
  assign ram_re = (state_reg == S_READ) && !rd_stage_reg;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[req_index] <= i_data;
    end
    if (ram_re) begin
      ram_q <= mem[rd_addr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (is_load) begin
            state_next = S_READ;
          end else if (is_output) begin
            state_next = S_TX;
          end else if (is_input) begin
            state_next = S_RX;
          end
        end
      end
      S_READ: if (rd_stage_reg) state_next = S_RESP;
      S_RESP: if (o_cdb_ready)  state_next = S_IDLE;
      S_TX:   if (o_tx_ready)   state_next = S_IDLE;
      S_RX:   if (i_rx_valid)   state_next = S_RESP;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      rsv_id_reg   <= '0;
      data_reg     <= '0;
      tx_byte_reg  <= '0;
      rd_addr_reg  <= '0;
      rd_stage_reg <= 1'b0;
    end else begin
      if (accept && (is_load || is_input)) begin
        rsv_id_reg <= i_rsv_id;
      end
      if (accept && is_load) begin
        rd_addr_reg <= req_index;
      end
      if (accept && is_output) begin
        tx_byte_reg <= i_data[7:0];
      end
      rd_stage_reg <= ram_re;
      if ((state_reg == S_READ) && rd_stage_reg) begin
        data_reg <= ram_q;
      end else if ((state_reg == S_RX) && i_rx_valid) begin
        data_reg <= {{(DATA_W-8){1'b0}}, i_rx_data};
      end
    end
  end

  // Handshake outputs are forced low while reset is held so nothing is consumed or emitted.
  always_comb begin
    i_ready     = 1'b0;
    o_cdb_valid = 1'b0;
    o_cdb       = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    i_rx_ready  = 1'b0;
    if (!nrst) begin
      unique case (state_reg)
        S_IDLE: i_ready = 1'b1;
        S_RESP: begin
          o_cdb_valid = 1'b1;
          o_cdb       = {rsv_id_reg, data_reg};
        end
        S_TX: begin
          o_tx_valid = 1'b1;
          o_tx_data  = tx_byte_reg;
        end
        S_RX:   i_rx_ready = 1'b1;
        default: i_ready = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_request_responder.sv
// Randomized bench for memory_request_responder: transaction-level scoreboard plus directed cases.
module tb_memory_request_responder;
  localparam int ADDR_W = 10, DATA_W = 32, RSV_ID_W = 4, INSTR_W = 5;
  localparam int CDB_W = RSV_ID_W + DATA_W;
  localparam logic [4:0] I_LOAD = 5'd1, I_LOADB = 5'd2, I_LOADR = 5'd3;
  localparam logic [4:0] I_STORE = 5'd4, I_STOREB = 5'd5, I_STORER = 5'd6;
  localparam logic [4:0] I_OUTPUT = 5'd7, I_INPUT = 5'd8, I_BOGUS = 5'd31;

  logic clk = 1'b0;
  logic nrst = 1'b1;
  logic i_valid = 1'b0;
  logic [INSTR_W-1:0] i_opcode = '0;
  logic [RSV_ID_W-1:0] i_rsv_id = '0;
  logic [DATA_W-1:0] i_address = '0, i_data = '0;
  logic i_ready, o_cdb_valid, o_tx_valid, i_rx_ready;
  logic [CDB_W-1:0] o_cdb;
  logic [7:0] o_tx_data;
  logic o_cdb_ready = 1'b0, o_tx_ready = 1'b0, i_rx_valid = 1'b0;
  logic [7:0] i_rx_data = '0;

  memory_request_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSV_ID_W(RSV_ID_W), .INSTR_W(INSTR_W), .CDB_W(CDB_W),
    .I_LOAD(I_LOAD), .I_LOADB(I_LOADB), .I_LOADR(I_LOADR),
    .I_STORE(I_STORE), .I_STOREB(I_STOREB), .I_STORER(I_STORER),
    .I_OUTPUT(I_OUTPUT), .I_INPUT(I_INPUT)
  ) dut (
    .clk(clk), .nrst(nrst), .i_valid(i_valid), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
    .i_address(i_address), .i_data(i_data), .i_ready(i_ready), .o_cdb(o_cdb),
    .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .o_tx_ready(o_tx_ready), .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data), .i_rx_ready(i_rx_ready)
  );

  always #5 clk = ~clk;

  int ntests = 0, nfail = 0;
  logic [DATA_W-1:0] mem_m [2**ADDR_W];
  logic [CDB_W-1:0] exp_cdb [$];
  logic [7:0] exp_tx [$];
  logic [RSV_ID_W-1:0] rx_rsv = '0;
  int cdb_mode = 0, tx_mode = 0, rx_mode = 0;  // 0 low, 1 high, 2 random
  logic [7:0] rx_byte_fixed = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    ntests++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Sink/source handshakes; updated 2 time units after the edge so the driver's mode changes apply.
  always @(posedge clk) begin
    #2;
    o_cdb_ready = (cdb_mode == 2) ? 1'($urandom_range(0, 1)) : (cdb_mode == 1);
    o_tx_ready  = (tx_mode == 2)  ? 1'($urandom_range(0, 1)) : (tx_mode == 1);
    i_rx_valid  = (rx_mode == 2)  ? 1'($urandom_range(0, 1)) : (rx_mode == 1);
    i_rx_data   = (rx_mode == 1)  ? rx_byte_fixed : 8'($urandom);
  end

  // Scoreboard: every handshake is matched against the model's expected queues.
  logic pv = 0, pr = 0, tv = 0, trd = 0;
  logic [CDB_W-1:0] pcdb = '0;
  logic [7:0] ptx = '0;
  always @(negedge clk) begin
    if (nrst) begin
      pv = 0; pr = 0; tv = 0; trd = 0;
    end else begin
      check("exclusive_valids", ($countones({o_cdb_valid, o_tx_valid, i_rx_ready}) > 1), 0);
      if (pv && !pr) begin
        check("cdb_hold_valid", o_cdb_valid, 1);
        check("cdb_hold_data", o_cdb, pcdb);
      end
      if (tv && !trd) begin
        check("tx_hold_valid", o_tx_valid, 1);
        check("tx_hold_data", o_tx_data, ptx);
      end
      if (o_cdb_valid && o_cdb_ready) begin
        if (exp_cdb.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL cdb_unexpected: got %h, expected no result", o_cdb);
        end else begin
          check("cdb_result", o_cdb, exp_cdb.pop_front());
        end
      end
      if (o_tx_valid && o_tx_ready) begin
        if (exp_tx.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL tx_unexpected: got %h, expected no byte", o_tx_data);
        end else begin
          check("tx_byte", o_tx_data, exp_tx.pop_front());
        end
      end
      if (i_rx_valid && i_rx_ready)
        exp_cdb.push_back({rx_rsv, {(DATA_W-8){1'b0}}, i_rx_data});
      pv = o_cdb_valid; pr = o_cdb_ready; pcdb = o_cdb;
      tv = o_tx_valid; trd = o_tx_ready; ptx = o_tx_data;
    end
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Present a request until accepted; the model is updated at the accept edge.
  task automatic do_req(input logic [4:0] op, input logic [3:0] rsv, input logic [31:0] addr,
                        input logic [31:0] data);
    int n = 0;
    i_valid = 1; i_opcode = op; i_rsv_id = rsv; i_address = addr; i_data = data;
    @(negedge clk);
    while (!i_ready && n < 500) begin @(negedge clk); n++; end
    if (!i_ready) begin
      ntests++; nfail++;
      $display("FAIL req_timeout: got i_ready=0, expected 1 within 500 cycles");
    end
    @(posedge clk); #1;
    i_valid = 0;
    if (op == I_STORE || op == I_STOREB || op == I_STORER) mem_m[addr[ADDR_W-1:0]] = data;
    else if (op == I_LOAD || op == I_LOADB || op == I_LOADR) exp_cdb.push_back({rsv, mem_m[addr[ADDR_W-1:0]]});
    else if (op == I_OUTPUT) exp_tx.push_back(data[7:0]);
    else if (op == I_INPUT) rx_rsv = rsv;
  endtask

  task automatic wait_cdb();
    int n = 0;
    @(negedge clk);
    while (!o_cdb_valid && n < 50) begin @(negedge clk); n++; end
    if (!o_cdb_valid) begin
      ntests++; nfail++;
      $display("FAIL cdb_timeout: got o_cdb_valid=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic pulse_reset();
    nrst = 1; align(); nrst = 0;
    exp_cdb.delete(); exp_tx.delete();
  endtask

  initial begin
    logic [4:0] op;
    logic [CDB_W-1:0] snap;
    int sel;
    repeat (2) @(posedge clk);
    #1; nrst = 0;
    @(negedge clk);
    check("reset_i_ready", i_ready, 1);
    check("reset_cdb_valid", o_cdb_valid, 0);
    check("reset_cdb", o_cdb, 0);
    check("reset_tx", {o_tx_valid, o_tx_data}, 0);
    check("reset_rx_ready", i_rx_ready, 0);
    align();

    // Store then load: result exactly two cycles after the load is accepted.
    cdb_mode = 1;
    do_req(I_STORE, 0, 32'd5, 32'hDEADBEEF);
    do_req(I_LOAD, 3, 32'd5, 0);
    @(negedge clk); check("lat_c1_ready", i_ready, 0); check("lat_c1_valid", o_cdb_valid, 0);
    @(negedge clk); check("lat_c2_ready", i_ready, 0); check("lat_c2_valid", o_cdb_valid, 0);
    @(negedge clk); check("lat_c3_valid", o_cdb_valid, 1); check("lat_c3_ready", i_ready, 0);
    check("lat_literal", o_cdb, {4'd3, 32'hDEADBEEF});
    align();

    // Upper address bits are ignored.
    do_req(I_STORE, 0, 32'h405, 32'h11);
    do_req(I_LOADB, 1, 32'h005, 0);
    wait_cdb(); check("alias_literal", o_cdb, {4'd1, 32'h11});
    align();

    // CDB backpressure for 5 cycles.
    cdb_mode = 0;
    do_req(I_LOAD, 2, 32'd5, 0);
    wait_cdb(); snap = o_cdb;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_cdb_stable", o_cdb, snap); check("bp_i_ready", i_ready, 0);
    end
    align(); cdb_mode = 1;
    @(negedge clk); check("bp_hs_valid", o_cdb_valid, 1); check("bp_hs_i_ready", i_ready, 0);
    align();
    @(negedge clk); check("bp_after_i_ready", i_ready, 1); check("bp_after_valid", o_cdb_valid, 0);
    align();

    // Transmit with backpressure.
    tx_mode = 0;
    do_req(I_OUTPUT, 0, 0, 32'h1234_5641);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_valid", o_tx_valid, 1); check("tx_literal", o_tx_data, 8'h41);
      check("tx_no_cdb", o_cdb_valid, 0); check("tx_i_ready", i_ready, 0);
    end
    align(); tx_mode = 1;
    align();
    @(negedge clk); check("tx_back_idle", i_ready, 1);
    align();

    // Receive after a 4-cycle wait.
    rx_mode = 0;
    do_req(I_INPUT, 7, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("rx_ready_wait", i_rx_ready, 1); check("rx_no_cdb", o_cdb_valid, 0);
    end
    align(); rx_byte_fixed = 8'h5A; rx_mode = 1;
    wait_cdb(); check("rx_literal", o_cdb, {4'd7, 32'h0000_005A});
    align(); rx_mode = 0;

    // Reset while a load result is pending: it must never appear.
    cdb_mode = 0;
    do_req(I_LOAD, 4, 32'd5, 0);
    wait_cdb(); align();
    pulse_reset();
    @(negedge clk);
    check("rst_resp_valid", o_cdb_valid, 0); check("rst_resp_cdb", o_cdb, 0);
    check("rst_resp_i_ready", i_ready, 1);
    cdb_mode = 1;
    repeat (5) align();

    // A store presented during reset is not written.
    do_req(I_STORE, 0, 32'd9, 32'h99);
    nrst = 1; i_valid = 1; i_opcode = I_STORE; i_address = 32'd9; i_data = 32'hBAD;
    align(); nrst = 0; i_valid = 0;
    do_req(I_LOADR, 5, 32'd9, 0);
    wait_cdb(); check("rst_store_literal", o_cdb, {4'd5, 32'h99});
    align();

    // Back-to-back stores then loads.
    for (int i = 0; i < 4; i++) do_req(I_STOREB, 0, i, 32'hA0 + i);
    for (int i = 0; i < 4; i++) do_req(I_LOAD, 4'(i), i, 0);
    for (int i = 4; i < 16; i++) do_req(I_STORE, 0, {$urandom_range(0, 1023), 10'(i)}, $urandom);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      cdb_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      tx_mode  = ($urandom_range(0, 3) == 0) ? 1 : 2;
      rx_mode  = 2;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: op = (sel == 0) ? I_STORE : (sel == 1) ? I_STOREB : I_STORER;
        3, 4, 5: op = (sel == 3) ? I_LOAD : (sel == 4) ? I_LOADB : I_LOADR;
        6: op = I_OUTPUT;
        7: op = I_INPUT;
        default: op = I_BOGUS;
      endcase
      do_req(op, 4'($urandom), {$urandom_range(0, 4194303), 10'($urandom_range(0, 15))}, $urandom);
    end

    // Drain outstanding results.
    cdb_mode = 1; tx_mode = 1; rx_mode = 2;
    for (int n = 0; n < 100 && (exp_cdb.size() != 0 || exp_tx.size() != 0 || !i_ready); n++)
      @(negedge clk);
    check("drain_cdb_empty", exp_cdb.size(), 0);
    check("drain_tx_empty", exp_tx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/memory_request_responder.md
Name: memory_request_responder

Overview:
- Sits on the memory side of the load/store unit's request port. Accepts one memory request per handshake: rsv id, opcode, address, store data.
- Stores write a local synchronous word RAM. Loads read it and return {rsv_id, data} on a CDB-format output.
- I_OUTPUT sends a byte to a transmit stream. I_INPUT waits for a byte on a receive stream and returns it on the CDB.

Parameters:
ADDR_W, 10, word-address width; RAM depth is 2**ADDR_W words of DATA_W bits.

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-high
i_valid  in  1  request valid
i_opcode  in  INSTR_W  request opcode
i_rsv_id  in  RSV_ID_W  rob id of request
i_address  in  DATA_W  computed address
i_data  in  DATA_W  store data
i_ready  out  1  request accepted when i_valid&i_ready
o_cdb  out  CDB_W  {rsv_id, data}, rsv_id in upper RSV_ID_W bits
o_cdb_valid  out  1  result valid
o_cdb_ready  in  1  result consumed when o_cdb_valid&o_cdb_ready
o_tx_valid  out  1  output byte valid
o_tx_data  out  8  output byte
o_tx_ready  in  1  byte consumed
i_rx_valid  in  1  input byte valid
i_rx_data  in  8  input byte
i_rx_ready  out  1  input byte consumed

Behaviour:
- Opcode classes:
  - store = I_STORE, I_STOREB, I_STORER.
  - load = I_LOAD, I_LOADB, I_LOADR.
  - Also I_OUTPUT and I_INPUT.
  - Any other opcode is accepted and dropped: no RAM write, no CDB result.
- RAM index = i_address[ADDR_W-1:0]; upper address bits are ignored. RAM contents are not cleared by reset.
- States:
  - IDLE: i_ready=1.
    - store: RAM write at accept edge, stay IDLE (throughput 1/cycle).
    - load: latch rsv_id, issue RAM read, go READ.
    - I_OUTPUT: latch i_data[7:0], go TX.
    - I_INPUT: latch rsv_id, go RX.
  - READ: i_ready=0. The RAM read data is registered into the result (data) register, then go RESP.
  - RESP: o_cdb_valid=1, o_cdb={rsv_id, data}. Hold o_cdb stable until o_cdb_ready, then go IDLE.
  - TX: o_tx_valid=1, o_tx_data=latched byte. On o_tx_ready go IDLE. No CDB result.
  - RX: i_rx_ready=1. On i_rx_valid, data={(DATA_W-8)'0, i_rx_data}, go RESP.
- i_ready=1 only in IDLE. No new request is accepted in the cycle a response completes; the next accept is the following cycle.
- Load latency: accept at edge N → o_cdb_valid high in the cycle after edge N+2 (registered RAM output plus one result register).
- Store followed immediately by load to the same index: the load returns the new data (the write happens at the accept edge, before the load's read edge).
- o_cdb_valid, o_tx_valid and i_rx_ready are never high together.
- Reset (nrst=1 at a clock edge):
  - State=IDLE.
  - o_cdb_valid=0, o_cdb=0, o_tx_valid=0, o_tx_data=0, i_rx_ready=0; i_ready=1 the cycle after reset.
  - An in-flight load, TX or RX is abandoned: no result is emitted and no RX byte is consumed.
  - A store presented in the reset cycle is not written.
- Backpressure: o_cdb_ready or o_tx_ready may stay low indefinitely. Outputs stay stable and i_ready stays 0 meanwhile.

Test Plan:
- Store 0xDEADBEEF to address 5, then load address 5 with rsv_id 3 → o_cdb={3, 0xDEADBEEF} exactly 2 cycles after load accept; i_ready=0 for those cycles and until the CDB handshake.
- Address aliasing, ADDR_W=10: store 0x11 at address 0x405, load address 0x005 → data 0x11.
- Load with o_cdb_ready held 0 for 5 cycles → o_cdb stable, i_ready=0 throughout. On the ready cycle, handshake completes; i_ready=1 the next cycle.
- I_OUTPUT with i_data=0x1234_5641 and o_tx_ready low for 3 cycles → o_tx_data=0x41 held; no o_cdb_valid; returns to IDLE after tx handshake.
- I_INPUT rsv_id 7, i_rx_valid asserted 4 cycles later with 0x5A → i_rx_ready=1 while waiting, then o_cdb={7, 0x0000005A}.
- Assert nrst during RESP of a pending load → o_cdb_valid=0 after the reset edge and the result is never emitted. Back-to-back stores to addresses 0..3 then loads return the stored values.
